apu_mixer: RTL and testbench
============================

# apu_mixer

Downstream of the per-channel voice stages. Sums the 9-bit channel outputs (pulse, triangle, noise, and so on) into one master sample. The sum is computed once per sample-rate strobe by a time-multiplexed accumulator with per-channel mute and master volume. A first-order delta-sigma modulator turns the held master sample into a 1-bit pin drive for an external RC filter.

## Interface
- `IN_WIDTH`, default 9: width of each channel input. The output width is `IN_WIDTH+2`.

- `i_clk` input 1: system clock. All logic is on the rising edge.
- `i_reset` input 1: synchronous, active-high reset.
- `i_sample_stb` input 1: single-cycle request to compute a new mix.
- `i_ch0` … `i_ch3` input `IN_WIDTH` each: unsigned channel levels, for example the 9-bit `o_output` of a channel.
- `i_mute` input 4: bit n high excludes channel n from the mix.
- `i_volume` input 4: master volume. The gain is `(i_volume+1)/16`.
- `o_sample` output `IN_WIDTH+2`: latest mixed sample, held between updates.
- `o_sample_valid` output 1: one-cycle pulse when `o_sample` updates.
- `o_busy` output 1: high while a mix is in progress.
- `o_overrun` output 1: one-cycle pulse when a strobe arrives while busy.
- `o_pdm` output 1: delta-sigma bitstream.

## Operation
- **States:** IDLE, ACCUM, SCALE. `o_busy` is `state != IDLE`.
- **IDLE:** when `i_sample_stb` is high, capture all four channels, `i_mute` and `i_volume` into shadow registers. Clear the accumulator, set the channel index to 0, and go to ACCUM.
- **ACCUM:**
  - Each cycle, add shadow channel[idx] to the accumulator, or add 0 if that channel's mute bit is set. Then increment idx.
  - After idx 3, go to SCALE.
  - The accumulator is `IN_WIDTH+2` bits. The maximum sum is 4·(2^IN_WIDTH−1), so it cannot overflow.
- **SCALE:**
  - Compute `o_sample` = (acc · (vol+1)) >> 4, using a full-width product with no rounding.
  - `i_volume`=15 gives unity gain.
  - Pulse `o_sample_valid` and return to IDLE.
- **Input stability:** live inputs are ignored after capture. Changes during ACCUM or SCALE do not affect the result in flight.
- **Strobe while busy:** the strobe is dropped, `o_overrun` pulses, and the current mix completes unaffected.
- **PDM modulator:**
  - Runs every clock, independent of the FSM.
  - `{carry, pacc}` = `pacc` + `o_sample`, where `pacc` is `IN_WIDTH+2` bits. `o_pdm` is the registered carry.
  - The ones density of `o_pdm` is `o_sample`/2^(IN_WIDTH+2).

## Timing
- **Reset values:** all outputs are 0. The state is IDLE, and idx, accumulator, shadows and `pacc` are 0.
- **Latency:**
  - With `i_sample_stb` high in cycle 0: ACCUM covers cycles 1–4 and SCALE is cycle 5.
  - `o_sample` holds the new value and `o_sample_valid` is high in cycle 6.
  - `o_busy` is high in cycles 1–5.
- **Minimum strobe spacing:** 6 cycles.
  - A strobe in cycle 6, while `o_sample_valid` is high and the state is IDLE, is accepted.
  - A strobe in cycles 1–5 produces `o_overrun` in the following cycle.
- **PDM update:** `o_pdm` uses the new `o_sample` from the cycle after `o_sample_valid`. The modulator state `pacc` is not reset on a sample update.
- **Reset during ACCUM or SCALE:** the mix is aborted, with no valid pulse. `o_sample` is 0 and `o_busy` is 0 in the cycle after reset is sampled.
- **Reset and strobe in the same cycle:** reset wins and the strobe is discarded.

## Configuration
- `APU_MIXER_PDM_EN`
  - Defined: the delta-sigma modulator is built and `o_pdm` behaves as above.
  - Undefined: there is no modulator logic, `pacc` is absent, and `o_pdm` is tied to 0. The mixer FSM and all other outputs are unchanged.

## Test plan
- **Basic mix:** ch0..3 = 100, 200, 300, 400; mute = 0; vol = 15; strobe in cycle 0 → `o_sample_valid` in cycle 6, `o_sample` = 1000, `o_busy` high cycles 1–5.
- **Volume:** same inputs, vol = 7 → `o_sample` = 500. Vol = 0 → 62.
- **Mute and capture:** mute = 4'b0101, vol = 15 → `o_sample` = 600. Changing `i_ch1` to 0 in cycle 2 still yields 600.
- **Overrun:** strobe in cycle 0 and cycle 3 → `o_overrun` pulses in cycle 4 and the result is 1000 in cycle 6. A strobe in cycle 6 is accepted, with valid in cycle 12.
- **PDM (macro defined):**
  - `o_sample` = 1024 → exactly 1024 ones in any 2048 consecutive cycles, alternating 0/1.
  - `o_sample` = 0 → constant 0.
  - Macro undefined → `o_pdm` stays 0.
- **Reset:** assert `i_reset` in cycle 3 of a mix → no valid pulse, `o_busy` = 0 and `o_sample` = 0 in cycle 4. The next strobe mixes normally.

Source files
------------

// File: rtl/apu_mixer.sv
// apu_mixer: time-multiplexed four-channel mixer with per-channel mute and
// master volume, followed by a first-order delta-sigma modulator on o_pdm.
// Optional feature macro: APU_MIXER_PDM_EN builds the modulator. When it is
// left undefined, o_pdm is tied low and no modulator state exists.
module apu_mixer #(
  parameter int unsigned IN_WIDTH = 9
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_sample_stb,
  input  logic [IN_WIDTH-1:0]   i_ch0,
  input  logic [IN_WIDTH-1:0]   i_ch1,
  input  logic [IN_WIDTH-1:0]   i_ch2,
  input  logic [IN_WIDTH-1:0]   i_ch3,
  input  logic [3:0]            i_mute,
  input  logic [3:0]            i_volume,
  output logic [IN_WIDTH+1:0]   o_sample,
  output logic                  o_sample_valid,
  output logic                  o_busy,
  output logic                  o_overrun,
  output logic                  o_pdm
);

  localparam int unsigned OW = IN_WIDTH + 2;
  // acc (OW bits) times vol+1 (5 bits)
  localparam int unsigned PW = OW + 5;

  typedef enum logic [1:0] {StIdle, StAccum, StScale} state_e;

  state_e                state_q;
  logic [1:0]            idx_q;
  logic [OW-1:0]         acc_q;
  logic [IN_WIDTH-1:0]   ch0_q, ch1_q, ch2_q, ch3_q;
  logic [3:0]            mute_q;
  logic [3:0]            vol_q;
  logic [OW-1:0]         sample_q;
  logic                  valid_q;
  logic                  overrun_q;

  logic [IN_WIDTH-1:0]   ch_sel;
  logic [OW-1:0]         add_val;
  logic [PW-1:0]         prod;
  logic [OW-1:0]         scaled;

  // Pick the shadowed channel for the current slot and apply its mute bit.
  always_comb begin
    ch_sel = '0;
    case (idx_q)
      2'd0:    ch_sel = ch0_q;
      2'd1:    ch_sel = ch1_q;
      2'd2:    ch_sel = ch2_q;
      default: ch_sel = ch3_q;
    endcase
    add_val = mute_q[idx_q] ? '0 : OW'(ch_sel);
    prod    = PW'(acc_q) * PW'({1'b0, vol_q} + 5'd1);
    // The max result is the max sum, so the truncation drops only zero bits.
    scaled  = OW'(prod >> 4);
  end

  // Mixer FSM: capture on strobe, accumulate four slots, scale, publish.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      acc_q     <= '0;
      ch0_q     <= '0;
      ch1_q     <= '0;
      ch2_q     <= '0;
      ch3_q     <= '0;
      mute_q    <= '0;
      vol_q     <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      overrun_q <= i_sample_stb && (state_q != StIdle);
      case (state_q)
        StIdle: begin
          if (i_sample_stb) begin
            ch0_q   <= i_ch0;
            ch1_q   <= i_ch1;
            ch2_q   <= i_ch2;
            ch3_q   <= i_ch3;
            mute_q  <= i_mute;
            vol_q   <= i_volume;
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= StAccum;
          end
        end
        StAccum: begin
          acc_q <= acc_q + add_val;
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_q <= StScale;
          end
        end
        StScale: begin
          sample_q <= scaled;
          valid_q  <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_sample       = sample_q;
  assign o_sample_valid = valid_q;
  assign o_busy         = (state_q != StIdle);
  assign o_overrun      = overrun_q;

`ifdef APU_MIXER_PDM_EN
  logic [OW-1:0] pacc_q;
  logic          pdm_q;
  logic [OW:0]   pdm_sum;

  // Carry out of the phase accumulator is the 1-bit density output.
  always_comb begin
    pdm_sum = {1'b0, pacc_q} + {1'b0, sample_q};
  end

  // Modulator runs every clock; phase is not disturbed by sample updates.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pacc_q <= '0;
      pdm_q  <= 1'b0;
    end else begin
      pacc_q <= pdm_sum[OW-1:0];
      pdm_q  <= pdm_sum[OW];
    end
  end

  assign o_pdm = pdm_q;
`else
  assign o_pdm = 1'b0;
`endif

endmodule

// File: tb/tb_apu_mixer.sv
// Testbench for apu_mixer: table-driven mixes with a scoreboard queue of
// expected samples, plus sequences for overrun, capture, reset and PDM.
module tb_apu_mixer;

  localparam int unsigned W  = 9;
  localparam int unsigned OW = W + 2;

  typedef struct packed {
    logic [W-1:0] ch0;
    logic [W-1:0] ch1;
    logic [W-1:0] ch2;
    logic [W-1:0] ch3;
    logic [3:0]   mute;
    logic [3:0]   vol;
    logic [31:0]  expv;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          stb;
  logic [W-1:0]  ch0, ch1, ch2, ch3;
  logic [3:0]    mute, vol;
  logic [OW-1:0] o_sample;
  logic          o_sample_valid, o_busy, o_overrun, o_pdm;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  apu_mixer #(.IN_WIDTH(W)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_sample_stb   (stb),
    .i_ch0          (ch0),
    .i_ch1          (ch1),
    .i_ch2          (ch2),
    .i_ch3          (ch3),
    .i_mute         (mute),
    .i_volume       (vol),
    .o_sample       (o_sample),
    .o_sample_valid (o_sample_valid),
    .o_busy         (o_busy),
    .o_overrun      (o_overrun),
    .o_pdm          (o_pdm)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int model(input vec_t v);
    int sum;
    sum = 0;
    if (!v.mute[0]) sum += int'(v.ch0);
    if (!v.mute[1]) sum += int'(v.ch1);
    if (!v.mute[2]) sum += int'(v.ch2);
    if (!v.mute[3]) sum += int'(v.ch3);
    return (sum * (int'(v.vol) + 1)) >> 4;
  endfunction

  // Scoreboard: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    int e;
    if (o_sample_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sample", int'(o_sample), e);
      end
    end
  end

  // One mix from cycle 0. extra: cycle of a second strobe (6 = accepted
  // back-to-back). perturb: cycle in which live inputs are scrambled.
  task automatic do_mix(input vec_t v, input int extra, input int perturb);
    int last;
    bit exp_busy, exp_valid, exp_ovr;
    @(posedge clk); #1;
    ch0 = v.ch0; ch1 = v.ch1; ch2 = v.ch2; ch3 = v.ch3;
    mute = v.mute; vol = v.vol; stb = 1'b1;
    exp_q.push_back(int'(v.expv));
    @(negedge clk);
    check("busy_c0", int'(o_busy), 0);
    last = (extra == 6) ? 12 : 6;
    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      stb = (c == extra);
      if (c == 6 && extra == 6) exp_q.push_back(int'(v.expv));
      if (c == perturb) begin
        ch1 = '0; mute = 4'hF; vol = 4'h0;
      end
      @(negedge clk);
      exp_busy  = (c <= 5) || (extra == 6 && c >= 7 && c <= 11);
      exp_valid = (c == 6) || (extra == 6 && c == 12);
      exp_ovr   = (extra >= 1 && extra <= 5 && c == extra + 1);
      check($sformatf("busy_c%0d", c), int'(o_busy), int'(exp_busy));
      check($sformatf("valid_c%0d", c), int'(o_sample_valid), int'(exp_valid));
      check($sformatf("overrun_c%0d", c), int'(o_overrun), int'(exp_ovr));
    end
    stb = 1'b0;
  endtask

  vec_t tbl[6];
  vec_t basic, quad, silent;

  initial begin
    int ones, flips, prev;
    rst = 1'b1; stb = 1'b0;
    ch0 = '0; ch1 = '0; ch2 = '0; ch3 = '0; mute = '0; vol = '0;

    tbl[0] = '{ch0: 9'd100, ch1: 9'd200, ch2: 9'd300, ch3: 9'd400,
               mute: 4'b0000, vol: 4'd15, expv: 32'd1000};
    tbl[1] = '{ch0: 9'd100, ch1: 9'd200, ch2: 9'd300, ch3: 9'd400,
               mute: 4'b0000, vol: 4'd7, expv: 32'd500};
    tbl[2] = '{ch0: 9'd100, ch1: 9'd200, ch2: 9'd300, ch3: 9'd400,
               mute: 4'b0000, vol: 4'd0, expv: 32'd62};
    tbl[3] = '{ch0: 9'd100, ch1: 9'd200, ch2: 9'd300, ch3: 9'd400,
               mute: 4'b0101, vol: 4'd15, expv: 32'd600};
    tbl[4] = '{ch0: 9'd511, ch1: 9'd511, ch2: 9'd511, ch3: 9'd511,
               mute: 4'b0000, vol: 4'd15, expv: 32'd2044};
    for (int i = 5; i < 6; i++) begin
      tbl[i].ch0  = W'($urandom_range(511));
      tbl[i].ch1  = W'($urandom_range(511));
      tbl[i].ch2  = W'($urandom_range(511));
      tbl[i].ch3  = W'($urandom_range(511));
      tbl[i].mute = 4'($urandom_range(15));
      tbl[i].vol  = 4'($urandom_range(15));
      tbl[i].expv = 32'(model(tbl[i]));
    end
    basic  = tbl[0];
    quad   = '{ch0: 9'd256, ch1: 9'd256, ch2: 9'd256, ch3: 9'd256,
               mute: 4'b0000, vol: 4'd15, expv: 32'd1024};
    silent = '{ch0: 9'd256, ch1: 9'd256, ch2: 9'd256, ch3: 9'd256,
               mute: 4'b1111, vol: 4'd15, expv: 32'd0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_sample", int'(o_sample), 0);
    check("rst_valid", int'(o_sample_valid), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_overrun", int'(o_overrun), 0);
    check("rst_pdm", int'(o_pdm), 0);

    for (int i = 0; i < 6; i++) do_mix(tbl[i], 0, 0);

    // Live inputs scrambled mid-mix must not disturb the captured mix.
    do_mix(tbl[3], 0, 2);
    // Strobe while busy is dropped and flagged.
    do_mix(basic, 3, 0);
    do_mix(basic, 5, 0);
    // Strobe on the valid cycle is accepted.
    do_mix(basic, 6, 0);

    // Reset in cycle 3 aborts the mix.
    @(posedge clk); #1;
    ch0 = basic.ch0; ch1 = basic.ch1; ch2 = basic.ch2; ch3 = basic.ch3;
    mute = basic.mute; vol = basic.vol; stb = 1'b1;
    @(posedge clk); #1 stb = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("abort_busy_c3", int'(o_busy), 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy_c4", int'(o_busy), 0);
    check("abort_sample_c4", int'(o_sample), 0);
    check("abort_valid_c4", int'(o_sample_valid), 0);
    for (int c = 5; c <= 9; c++) begin
      @(negedge clk);
      check("abort_valid", int'(o_sample_valid), 0);
      check("abort_busy", int'(o_busy), 0);
    end

    // Reset and strobe together: reset wins.
    @(posedge clk); #1 rst = 1'b1; stb = 1'b1;
    @(posedge clk); #1 rst = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("rst_stb_busy", int'(o_busy), 0);
    @(negedge clk);
    check("rst_stb_busy2", int'(o_busy), 0);

    do_mix(tbl[1], 0, 0);

    // PDM with sample 1024: half density, strictly alternating.
    do_mix(quad, 0, 0);
    repeat (2) @(negedge clk);
    ones = 0; flips = 0; prev = int'(o_pdm);
    for (int k = 0; k < 2048; k++) begin
      @(negedge clk);
      if (o_pdm === 1'b1) ones++;
      if (int'(o_pdm) == prev) flips++;
      prev = int'(o_pdm);
    end
`ifdef APU_MIXER_PDM_EN
    check("pdm_ones_1024", ones, 1024);
    check("pdm_alternate_faults", flips, 0);
`else
    check("pdm_off_ones", ones, 0);
`endif

    // PDM with sample 0: constant low.
    do_mix(silent, 0, 0);
    repeat (2) @(negedge clk);
    ones = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (o_pdm !== 1'b0) ones++;
    end
    check("pdm_zero_ones", ones, 0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
